// File: rtl/opl_timer_ctrl.sv
// OPL timer control/status: decodes bank-0 timer register writes, drives timer presets/starts,
// latches overflow flags into the status byte and IRQ. Overflow rise to irq_n low takes 2 clk edges.
module opl_timer_ctrl #(
  parameter int         REG_TIMER_WIDTH = 8,
  parameter logic [7:0] TIMER1_ADDR     = 8'h02,
  parameter logic [7:0] TIMER2_ADDR     = 8'h03,
  parameter logic [7:0] CTRL_ADDR       = 8'h04
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       wr,
  input  logic                       bank,
  input  logic [7:0]                 address,
  input  logic [7:0]                 din,
  input  logic                       timer1_overflow,
  input  logic                       timer2_overflow,
  output logic [REG_TIMER_WIDTH-1:0] timer1_init,
  output logic                       timer1_start,
  output logic [REG_TIMER_WIDTH-1:0] timer2_init,
  output logic                       timer2_start,
  output logic [7:0]                 status,
  output logic                       irq_n
);

  logic       wr_en;
  logic       wr_t1;
  logic       wr_t2;
  logic       wr_ctrl;
  logic       irq_rst;
  logic       ctrl_cfg;
  logic [1:0] ovf_s;
  logic [1:0] ovf_h;
  logic [1:0] ovf_rise;
  logic       mask1;
  logic       mask2;
  logic       ft1;
  logic       ft2;
  logic       ft1_nxt;
  logic       ft2_nxt;
  logic       unused_din;

  assign wr_en    = wr & ~bank;
  assign wr_t1    = wr_en && (address == TIMER1_ADDR);
  assign wr_t2    = wr_en && (address == TIMER2_ADDR);
  assign wr_ctrl  = wr_en && (address == CTRL_ADDR);
  assign irq_rst  = wr_ctrl & din[7];
  assign ctrl_cfg = wr_ctrl & ~din[7];

  assign unused_din = ^din[4:2];

  // Detect and history stages keep sampling while reset is held, so an overflow level
  // already high at release is seen as steady rather than as a fresh rising edge.
  always_ff @(posedge clk) begin
    ovf_s <= {timer2_overflow, timer1_overflow};
    ovf_h <= ovf_s;
  end

  assign ovf_rise = ovf_s & ~ovf_h;

  // Priority per flag: mask write clears > overflow set > IRQ-reset clear > hold.
  always_comb begin
    ft1_nxt = ft1;
    ft2_nxt = ft2;
    if (ovf_rise[0] && !mask1) begin
      ft1_nxt = 1'b1;
    end else if (irq_rst) begin
      ft1_nxt = 1'b0;
    end
    if (ovf_rise[1] && !mask2) begin
      ft2_nxt = 1'b1;
    end else if (irq_rst) begin
      ft2_nxt = 1'b0;
    end
    if (ctrl_cfg && din[6]) begin
      ft1_nxt = 1'b0;
    end
    if (ctrl_cfg && din[5]) begin
      ft2_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      timer1_init  <= '0;
      timer2_init  <= '0;
      timer1_start <= 1'b0;
      timer2_start <= 1'b0;
      mask1        <= 1'b0;
      mask2        <= 1'b0;
      ft1          <= 1'b0;
      ft2          <= 1'b0;
    end else begin
      if (wr_t1) begin
        timer1_init <= din[REG_TIMER_WIDTH-1:0];
      end
      if (wr_t2) begin
        timer2_init <= din[REG_TIMER_WIDTH-1:0];
      end
      if (ctrl_cfg) begin
        mask1        <= din[6];
        mask2        <= din[5];
        timer2_start <= din[1];
        timer1_start <= din[0];
      end
      ft1 <= ft1_nxt;
      ft2 <= ft2_nxt;
    end
  end

  assign status = {ft1 | ft2, ft1, ft2, 5'b0};
  assign irq_n  = ~(ft1 | ft2);

endmodule
